// File: rtl/led_display_ctrl.sv
// -----------------------------------------------------------------------------
// led_display_ctrl
//   Bus-attached hex display peripheral. Holds NUM_WORDS 16-bit display words
//   and a control register (EN, BLINK), inserts WAIT_CYCLES wait states on every
//   access and scans a 7-segment bank of 4*NUM_WORDS digits, one digit at a time.
//
// Ports
//   clk          system clock, rising edge
//   reset        asynchronous active-high reset
//   needWait_o   high while the current access is not yet complete
//   addr_i       register select (0..NUM_WORDS-1 data, NUM_WORDS control)
//   re_i, we_i   read / write strobes (both high = write)
//   data_io      bidirectional data bus, driven only for a pure read
//   seg_o        active-high segments {g,f,e,d,c,b,a} of the lit digit
//   digit_sel_o  one-hot active-high digit enable, all-zero when blanked
// -----------------------------------------------------------------------------
module led_display_ctrl #(
    parameter int NUM_WORDS   = 2,
    parameter int ADDR_W      = 2,
    parameter int WAIT_CYCLES = 1,
    parameter int SCAN_DIV    = 1024,
    parameter int BLINK_DIV   = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    output logic                     needWait_o,
    input  logic [ADDR_W-1:0]        addr_i,
    input  logic                     re_i,
    input  logic                     we_i,
    inout  wire  [15:0]              data_io,
    output logic [6:0]               seg_o,
    output logic [4*NUM_WORDS-1:0]   digit_sel_o
);

    localparam int DIGITS  = 4 * NUM_WORDS;
    localparam int WAIT_W  = (WAIT_CYCLES > 0) ? $clog2(WAIT_CYCLES + 1) : 1;
    localparam int SCAN_W  = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int IDX_W   = $clog2(DIGITS);
    localparam int BLINK_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

    localparam logic [WAIT_W-1:0]  WAIT_MAX   = WAIT_W'(WAIT_CYCLES);
    localparam logic [SCAN_W-1:0]  SCAN_LAST  = SCAN_W'(SCAN_DIV - 1);
    localparam logic [IDX_W-1:0]   IDX_LAST   = IDX_W'(DIGITS - 1);
    localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_DIV - 1);
    localparam logic [ADDR_W-1:0]  CTRL_ADDR  = ADDR_W'(NUM_WORDS);
    localparam logic [DIGITS-1:0]  SEL_ONE    = {{(DIGITS-1){1'b0}}, 1'b1};

    // Hex nibble to active-high {g,f,e,d,c,b,a} segment pattern.
    function automatic logic [6:0] seg7(input logic [3:0] nib);
        logic [6:0] s;
        case (nib)
            4'h0:    s = 7'h3F;
            4'h1:    s = 7'h06;
            4'h2:    s = 7'h5B;
            4'h3:    s = 7'h4F;
            4'h4:    s = 7'h66;
            4'h5:    s = 7'h6D;
            4'h6:    s = 7'h7D;
            4'h7:    s = 7'h07;
            4'h8:    s = 7'h7F;
            4'h9:    s = 7'h6F;
            4'hA:    s = 7'h77;
            4'hB:    s = 7'h7C;
            4'hC:    s = 7'h39;
            4'hD:    s = 7'h5E;
            4'hE:    s = 7'h79;
            4'hF:    s = 7'h71;
            default: s = 7'h00;
        endcase
        return s;
    endfunction

    // State
    logic [15:0]        data_r [NUM_WORDS];
    logic [1:0]         ctrl_r;
    logic [WAIT_W-1:0]  wait_cnt_r;
    logic [SCAN_W-1:0]  scan_cnt_r;
    logic [IDX_W-1:0]   idx_r;
    logic [BLINK_W-1:0] blink_cnt_r;
    logic               phase_r;
    logic [6:0]         seg_r;
    logic [DIGITS-1:0]  sel_r;

    // Combinational
    logic               strobe_s;
    logic               need_wait_s;
    logic               commit_s;
    logic [15:0]        rdata_s;
    logic               scan_wrap_s;
    logic               round_wrap_s;
    logic [SCAN_W-1:0]  scan_nxt_s;
    logic [IDX_W-1:0]   idx_nxt_s;
    logic [BLINK_W-1:0] blink_nxt_s;
    logic               phase_nxt_s;
    logic [1:0]         ctrl_nxt_s;
    logic [15:0]        word_s;
    logic [3:0]         nib_s;
    logic [6:0]         seg_nxt_s;
    logic [DIGITS-1:0]  sel_nxt_s;

    // Bus handshake and read mux; reset forces needWait low and releases the bus.
    always_comb begin
        strobe_s    = re_i | we_i;
        need_wait_s = 1'b0;
        commit_s    = 1'b0;
        rdata_s     = 16'h0000;
        if (!reset && strobe_s && (wait_cnt_r < WAIT_MAX)) begin
            need_wait_s = 1'b1;
        end else begin
            need_wait_s = 1'b0;
        end
        commit_s = we_i & ~need_wait_s & ~reset;
        for (int k = 0; k < NUM_WORDS; k++) begin
            rdata_s = (addr_i == ADDR_W'(k)) ? data_r[k] : rdata_s;
        end
        if (addr_i == CTRL_ADDR) begin
            rdata_s = {14'h0000, ctrl_r};
        end else begin
            rdata_s = rdata_s;
        end
    end

    assign needWait_o = need_wait_s;
    assign data_io    = (re_i && !we_i && !reset) ? rdata_s : 16'hzzzz;

    // Scan / blink next state; outputs are precomputed from next state so the
    // registered seg/digit_sel always match the registered counters.
    always_comb begin
        scan_wrap_s  = (scan_cnt_r == SCAN_LAST);
        round_wrap_s = scan_wrap_s && (idx_r == IDX_LAST);
        scan_nxt_s   = scan_wrap_s ? {SCAN_W{1'b0}} : (scan_cnt_r + 1'b1);
        idx_nxt_s    = idx_r;
        blink_nxt_s  = blink_cnt_r;
        phase_nxt_s  = phase_r;
        word_s       = 16'h0000;
        if (scan_wrap_s) begin
            idx_nxt_s = (idx_r == IDX_LAST) ? {IDX_W{1'b0}} : (idx_r + 1'b1);
        end else begin
            idx_nxt_s = idx_r;
        end
        if (round_wrap_s) begin
            if (blink_cnt_r == BLINK_LAST) begin
                blink_nxt_s = {BLINK_W{1'b0}};
                phase_nxt_s = ~phase_r;
            end else begin
                blink_nxt_s = blink_cnt_r + 1'b1;
                phase_nxt_s = phase_r;
            end
        end else begin
            blink_nxt_s = blink_cnt_r;
            phase_nxt_s = phase_r;
        end
        if (commit_s && (addr_i == CTRL_ADDR)) begin
            ctrl_nxt_s = data_io[1:0];
        end else begin
            ctrl_nxt_s = ctrl_r;
        end
        // Segments are latched only when the scan moves to a new digit, using
        // the word contents before any write landing on the same edge.
        for (int k = 0; k < NUM_WORDS; k++) begin
            word_s = ((idx_nxt_s >> 2'd2) == IDX_W'(k)) ? data_r[k] : word_s;
        end
        nib_s     = word_s[{idx_nxt_s[1:0], 2'b00} +: 4];
        seg_nxt_s = scan_wrap_s ? seg7(nib_s) : seg_r;
        if (!ctrl_nxt_s[0] || (ctrl_nxt_s[1] && phase_nxt_s)) begin
            sel_nxt_s = {DIGITS{1'b0}};
        end else begin
            sel_nxt_s = SEL_ONE << idx_nxt_s;
        end
    end

    // Register file: data words and control, written on the completing edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int k = 0; k < NUM_WORDS; k++) begin
                data_r[k] <= 16'h0000;
            end
            ctrl_r <= 2'b01;
        end else begin
            for (int k = 0; k < NUM_WORDS; k++) begin
                if (commit_s && (addr_i == ADDR_W'(k))) begin
                    data_r[k] <= data_io;
                end
            end
            ctrl_r <= ctrl_nxt_s;
        end
    end

    // Wait-state counter: counts waiting cycles, clears on completion or idle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wait_cnt_r <= {WAIT_W{1'b0}};
        end else if (need_wait_s) begin
            wait_cnt_r <= wait_cnt_r + 1'b1;
        end else begin
            wait_cnt_r <= {WAIT_W{1'b0}};
        end
    end

    // Scan, blink and registered display outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            scan_cnt_r  <= {SCAN_W{1'b0}};
            idx_r       <= {IDX_W{1'b0}};
            blink_cnt_r <= {BLINK_W{1'b0}};
            phase_r     <= 1'b0;
            seg_r       <= seg7(4'h0);
            sel_r       <= SEL_ONE;
        end else begin
            scan_cnt_r  <= scan_nxt_s;
            idx_r       <= idx_nxt_s;
            blink_cnt_r <= blink_nxt_s;
            phase_r     <= phase_nxt_s;
            seg_r       <= seg_nxt_s;
            sel_r       <= sel_nxt_s;
        end
    end

    assign seg_o       = seg_r;
    assign digit_sel_o = sel_r;

endmodule

// File: tb/tb_led_display_ctrl.sv
// Self-checking bench for led_display_ctrl: directed sequences plus random bus
// traffic, compared every cycle against a cycle-count based reference model.
module tb_led_display_ctrl;

    localparam int WC = 3;
    localparam int SD = 4;
    localparam int BD = 2;
    localparam int NW = 2;
    localparam int AW = 2;
    localparam int ND = 4 * NW;

    localparam logic [6:0] SEG_TAB [16] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
        7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

    logic          clk = 1'b0;
    logic          reset;
    logic [AW-1:0] addr_i;
    logic          re_i;
    logic          we_i;
    wire  [15:0]   data_io;
    logic [15:0]   tb_data;
    logic          tb_drv;
    logic          needWait_o;
    logic [6:0]    seg_o;
    logic [ND-1:0] digit_sel_o;

    assign data_io = tb_drv ? tb_data : 16'hzzzz;

    always #5 clk = ~clk;

    led_display_ctrl #(
        .NUM_WORDS(NW), .ADDR_W(AW), .WAIT_CYCLES(WC), .SCAN_DIV(SD), .BLINK_DIV(BD)
    ) dut (
        .clk(clk), .reset(reset), .needWait_o(needWait_o), .addr_i(addr_i),
        .re_i(re_i), .we_i(we_i), .data_io(data_io), .seg_o(seg_o),
        .digit_sel_o(digit_sel_o)
    );

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model: register contents, cycles since reset, waiting cycles
    // of the current access and the segment pattern latched for the lit digit.
    logic [15:0] m_data [NW];
    logic [1:0]  m_ctrl;
    int          m_n;
    int          m_wait;
    logic [6:0]  m_seg;

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
    endtask

    function automatic logic [15:0] m_read(input int a);
        if (a < NW) return m_data[a];
        else if (a == NW) return {14'h0000, m_ctrl};
        else return 16'h0000;
    endfunction

    function automatic logic [3:0] m_nib(input int d);
        logic [15:0] w;
        w = m_data[d / 4];
        return w[(d % 4) * 4 +: 4];
    endfunction

    task automatic m_reset();
        for (int k = 0; k < NW; k++) m_data[k] = 16'h0000;
        m_ctrl = 2'b01;
        m_n    = 0;
        m_wait = 0;
        m_seg  = SEG_TAB[0];
    endtask

    // One bus cycle: drive at negedge, check outputs, then advance the model.
    task automatic cycle(input logic rst, input logic re, input logic we,
                         input logic [AW-1:0] a, input logic [15:0] d, output logic done);
        logic strobe, exp_wait, blank;
        int idx;
        @(negedge clk);
        reset = rst; re_i = re; we_i = we; addr_i = a; tb_data = d; tb_drv = we;
        if (rst) m_reset();
        #1;
        strobe   = re | we;
        exp_wait = !rst && strobe && (m_wait < WC);
        done     = !rst && strobe && !exp_wait;
        idx      = (m_n / SD) % ND;
        blank    = !m_ctrl[0] || (m_ctrl[1] && (((m_n / (SD * ND * BD)) % 2) == 1));
        check("needWait", {15'h0000, needWait_o}, {15'h0000, exp_wait});
        check("digit_sel", {8'h00, digit_sel_o}, blank ? 16'h0000 : 16'(1 << idx));
        check("seg", {9'h000, seg_o}, {9'h000, m_seg});
        if (re && !we && !rst) begin
            if (done) check("rdata", data_io, m_read(int'(a)));
        end else if (we) begin
            check("bus_hold", data_io, d);
        end else begin
            check("bus_z", data_io, 16'hzzzz);
        end
        @(posedge clk);
        if (!rst) begin
            m_n++;
            if ((m_n % SD) == 0) m_seg = SEG_TAB[m_nib((m_n / SD) % ND)];
            if (done) begin
                m_wait = 0;
                if (we) begin
                    if (int'(a) < NW) m_data[a] = d;
                    else if (int'(a) == NW) m_ctrl = d[1:0];
                end
            end else if (strobe) begin
                m_wait++;
            end else begin
                m_wait = 0;
            end
        end
    endtask

    task automatic access(input logic re, input logic we, input logic [AW-1:0] a, input logic [15:0] d);
        logic done;
        int k;
        done = 1'b0;
        k = 0;
        while (!done && k < WC + 2) begin
            cycle(1'b0, re, we, a, d, done);
            k++;
        end
    endtask

    task automatic idle(input int cycles);
        logic done;
        for (int i = 0; i < cycles; i++) cycle(1'b0, 1'b0, 1'b0, 2'd0, 16'h0000, done);
    endtask

    initial begin
        logic done;
        logic re, we;
        logic [AW-1:0] a;
        logic [15:0] d;
        int r;
        reset = 1'b1; re_i = 1'b0; we_i = 1'b0; addr_i = '0; tb_data = 16'h0000; tb_drv = 1'b0;
        m_reset();
        cycle(1'b1, 1'b0, 1'b0, 2'd0, 16'h0000, done);
        cycle(1'b1, 1'b1, 1'b0, 2'd2, 16'h0000, done);

        // Control reads 0001 after reset, data word 0 reads 0000.
        access(1'b1, 1'b0, 2'd2, 16'h0000);
        access(1'b1, 1'b0, 2'd0, 16'h0000);
        // Write BEEF to word 1, read back, let digits 4..7 scan.
        access(1'b0, 1'b1, 2'd1, 16'hBEEF);
        access(1'b1, 1'b0, 2'd1, 16'h0000);
        idle(80);
        // Blink then fully off, then back on.
        access(1'b0, 1'b1, 2'd2, 16'h0003);
        idle(300);
        access(1'b0, 1'b1, 2'd2, 16'h0000);
        idle(70);
        access(1'b0, 1'b1, 2'd2, 16'hFFFD);
        // Unmapped address and combined strobes.
        access(1'b0, 1'b1, 2'd3, 16'hFFFF);
        access(1'b1, 1'b0, 2'd3, 16'h0000);
        access(1'b1, 1'b1, 2'd0, 16'h5A5A);
        access(1'b1, 1'b0, 2'd0, 16'h0000);
        // Reset during the second wait cycle of a write, strobe kept high.
        access(1'b0, 1'b1, 2'd1, 16'h1234);
        cycle(1'b0, 1'b0, 1'b1, 2'd0, 16'h9999, done);
        cycle(1'b1, 1'b0, 1'b1, 2'd0, 16'h9999, done);
        cycle(1'b1, 1'b0, 1'b1, 2'd0, 16'h9999, done);
        access(1'b0, 1'b1, 2'd0, 16'h9999);
        access(1'b1, 1'b0, 2'd1, 16'h0000);
        access(1'b1, 1'b0, 2'd0, 16'h0000);

        // Random traffic with occasional resets in the middle of an access.
        for (int i = 0; i < 250; i++) begin
            r  = $urandom_range(0, 2);
            re = (r != 1);
            we = (r != 0);
            a  = AW'($urandom_range(0, 3));
            d  = 16'($urandom);
            if ((a == 2'd2) && we && ($urandom_range(0, 3) != 0)) d[0] = 1'b1;
            if ($urandom_range(0, 99) < 5) begin
                cycle(1'b0, re, we, a, d, done);
                cycle(1'b1, re, we, a, d, done);
            end
            access(re, we, a, d);
            idle($urandom_range(0, 3));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
